// File: rtl/cpu_rd_pkg.sv
// Shared types and constants for the Z80 read sequencer.
package cpu_rd_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_e;

  localparam int NREQ_DEF    = 7;
  localparam int WBITS_DEF   = 4;
  localparam int TIMEOUT_DEF = 64;

  localparam logic [7:0] FLOAT_BYTE = 8'hFF;
  localparam logic [7:0] RESET_BYTE = 8'h00;

  localparam int REQ_ROM     = 0;
  localparam int REQ_PORTCON = 1;
  localparam int REQ_RAM     = 2;
  localparam int REQ_LED     = 3;
  localparam int REQ_IOBYTE  = 4;
  localparam int REQ_USBRXD  = 5;
  localparam int REQ_USBSTAT = 6;
endpackage

// File: rtl/cpu_rd_prio_enc.sv
// Lowest-set-bit priority encoder: one-hot grant plus binary index.
module cpu_rd_prio_enc #(
  parameter int N  = 7,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Scan from the top so the lowest set bit is the final writer.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
      end
    end
  end

  assign any = |req;
endmodule

// File: rtl/cpu_read_sequencer.sv
// Z80 read-cycle sequencer: fixed-priority grant, wait-state insertion, registered DI.
// Optional WAIT timeout abort enabled by defining SEQ_TIMEOUT_EN.
module cpu_read_sequencer
  import cpu_rd_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int WBITS   = WBITS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                  pll0_250MHz,
  input  logic                  n_reset,
  input  logic                  cpu_rd_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WBITS-1:0] wait_cfg,
  input  logic [NREQ-1:0]       dev_ready,
  input  logic [NREQ*8-1:0]     dev_data,
  output logic [NREQ-1:0]       grant,
  output logic                  cpu_wait_n,
  output logic [7:0]            cpu_di,
  output logic                  busy
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic                  timeout
`endif
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e              state_q, state_d;
  logic [NREQ-1:0]     grant_q, grant_d;
  logic [IW-1:0]       gidx_q, gidx_d;
  logic [WBITS-1:0]    cnt_q, cnt_d;
  logic                wait_n_q, wait_n_d;
  logic [7:0]          di_q, di_d;

  logic [NREQ-1:0][WBITS-1:0] wcfg_a;
  logic [NREQ-1:0][7:0]       data_a;
  logic [NREQ-1:0]            enc_onehot;
  logic [IW-1:0]              enc_idx;
  logic                       enc_any;
  logic                       tmo_hit;

  assign wcfg_a = wait_cfg;
  assign data_a = dev_data;

  cpu_rd_prio_enc #(.N(NREQ), .IW(IW)) u_enc (
    .req    (req),
    .onehot (enc_onehot),
    .idx    (enc_idx),
    .any    (enc_any)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;
  logic          tmo_q;

  // tcnt_q equals the number of WAIT edges already taken; abort on the TIMEOUT-th.
  assign tmo_hit = (state_q == WAIT) && !cpu_rd_n && (tcnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else if (state_q == IDLE && state_d == WAIT) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else if (state_q == WAIT) begin
      tcnt_q <= tcnt_q + 1'b1;
      if (tmo_hit) tmo_q <= 1'b1;
    end
  end

  assign timeout = tmo_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT > 0);
  assign tmo_hit        = 1'b0;
`endif

  always_ff @(posedge pll0_250MHz or negedge n_reset) begin
    if (!n_reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      gidx_q   <= '0;
      cnt_q    <= '0;
      wait_n_q <= 1'b1;
      di_q     <= RESET_BYTE;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      cnt_q    <= cnt_d;
      wait_n_q <= wait_n_d;
      di_q     <= di_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gidx_d   = gidx_q;
    cnt_d    = cnt_q;
    wait_n_d = wait_n_q;
    di_d     = di_q;
    unique case (state_q)
      IDLE: begin
        if (!cpu_rd_n) begin
          if (enc_any) begin
            grant_d  = enc_onehot;
            gidx_d   = enc_idx;
            cnt_d    = wcfg_a[enc_idx];
            wait_n_d = 1'b0;
            state_d  = WAIT;
          end else begin
            di_d    = FLOAT_BYTE;
            state_d = HOLD;
          end
        end
      end
      WAIT: begin
        if (cpu_rd_n) begin
          grant_d  = '0;
          wait_n_d = 1'b1;
          state_d  = IDLE;
        end else if (tmo_hit) begin
          di_d     = FLOAT_BYTE;
          wait_n_d = 1'b1;
          state_d  = HOLD;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (dev_ready[gidx_q]) begin
          di_d     = data_a[gidx_q];
          wait_n_d = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (cpu_rd_n) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        grant_d  = '0;
        wait_n_d = 1'b1;
        state_d  = IDLE;
      end
    endcase
  end

  assign grant      = grant_q;
  assign cpu_wait_n = wait_n_q;
  assign cpu_di     = di_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_cpu_read_sequencer.sv
// Directed bench for cpu_read_sequencer; timeout scenario only when SEQ_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_cpu_read_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_n;
  logic [6:0]  req;
  logic [27:0] wait_cfg;
  logic [6:0]  dev_ready;
  logic [55:0] dev_data;
  logic [6:0]  grant;
  logic        wait_n;
  logic [7:0]  di;
  logic        busy;
`ifdef SEQ_TIMEOUT_EN
  logic        tmo;
`endif

  int tests = 0;
  int fails = 0;

  always #2 clk = ~clk;

  cpu_read_sequencer dut (
    .pll0_250MHz (clk),
    .n_reset     (rst_n),
    .cpu_rd_n    (rd_n),
    .req         (req),
    .wait_cfg    (wait_cfg),
    .dev_ready   (dev_ready),
    .dev_data    (dev_data),
    .grant       (grant),
    .cpu_wait_n  (wait_n),
    .cpu_di      (di),
    .busy        (busy)
`ifdef SEQ_TIMEOUT_EN
    ,
    .timeout     (tmo)
`endif
  );

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd_n = 1'b1; req = '0; wait_cfg = '0; dev_ready = '1; dev_data = '0;
    #5;
    tests++; if (grant !== 7'b0) begin fails++; $display("FAIL reset_grant got %b exp 0", grant); end
    tests++; if (wait_n !== 1'b1) begin fails++; $display("FAIL reset_wait_n got %b exp 1", wait_n); end
    tests++; if (di !== 8'h00) begin fails++; $display("FAIL reset_di got %h exp 00", di); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    edge1();
  endtask

  task automatic test_wait_states();
    wait_cfg[2*4 +: 4] = 4'd3;
    dev_data[2*8 +: 8] = 8'hA5;
    rd_n = 1'b0; req = 7'b0000100;
    for (int i = 0; i < 4; i++) begin
      edge1();
      tests++; if (wait_n !== 1'b0) begin fails++; $display("FAIL ws_wait_low edge%0d got %b exp 0", i, wait_n); end
      tests++; if (grant !== 7'b0000100) begin fails++; $display("FAIL ws_grant edge%0d got %b exp 0000100", i, grant); end
    end
    edge1();
    tests++; if (wait_n !== 1'b1) begin fails++; $display("FAIL ws_wait_rel got %b exp 1", wait_n); end
    tests++; if (di !== 8'hA5) begin fails++; $display("FAIL ws_di got %h exp a5", di); end
    edge1();
    tests++; if (grant !== 7'b0000100 || di !== 8'hA5) begin fails++; $display("FAIL ws_hold got %b/%h exp 0000100/a5", grant, di); end
    rd_n = 1'b1;
    edge1();
    tests++; if (grant !== 7'b0 || busy !== 1'b0) begin fails++; $display("FAIL ws_end got %b/%b exp 0/0", grant, busy); end
    tests++; if (di !== 8'hA5) begin fails++; $display("FAIL ws_di_kept got %h exp a5", di); end
  endtask

  // Starts immediately after the previous IDLE edge: earliest back-to-back cycle.
  task automatic test_priority();
    wait_cfg[0 +: 4] = 4'd2;
    dev_data[0 +: 8] = 8'h3C;
    rd_n = 1'b0; req = 7'b1000011;
    edge1();
    tests++; if (grant !== 7'b0000001) begin fails++; $display("FAIL prio_grant got %b exp 0000001", grant); end
    tests++; if (wait_n !== 1'b0) begin fails++; $display("FAIL prio_wait got %b exp 0", wait_n); end
    req = 7'b0000010;
    edge1();
    edge1();
    tests++; if (grant !== 7'b0000001) begin fails++; $display("FAIL prio_latched got %b exp 0000001", grant); end
    edge1();
    tests++; if (di !== 8'h3C || wait_n !== 1'b1) begin fails++; $display("FAIL prio_data got %h/%b exp 3c/1", di, wait_n); end
    rd_n = 1'b1; req = '0;
    edge1();
    tests++; if (grant !== 7'b0) begin fails++; $display("FAIL prio_end got %b exp 0", grant); end
  endtask

  task automatic test_unclaimed();
    rd_n = 1'b0; req = '0;
    edge1();
    tests++; if (di !== 8'hFF) begin fails++; $display("FAIL unc_di got %h exp ff", di); end
    tests++; if (wait_n !== 1'b1 || grant !== 7'b0 || busy !== 1'b1) begin fails++; $display("FAIL unc_ctl got w%b g%b b%b exp w1 g0 b1", wait_n, grant, busy); end
    edge1();
    rd_n = 1'b1;
    edge1();
    tests++; if (busy !== 1'b0 || di !== 8'hFF) begin fails++; $display("FAIL unc_end got b%b di%h exp b0 ff", busy, di); end
  endtask

  task automatic test_ready();
    int lowcnt = 0;
    wait_cfg[5*4 +: 4] = 4'd0;
    dev_data[5*8 +: 8] = 8'h5A;
    dev_ready[5] = 1'b0;
    rd_n = 1'b0; req = 7'b0100000;
    for (int e = 0; e < 40; e++) begin
      edge1();
      if (wait_n === 1'b0) lowcnt++;
      else break;
      if (e == 10) dev_ready[5] = 1'b1;
    end
    tests++; if (lowcnt != 11) begin fails++; $display("FAIL rdy_low_cycles got %0d exp 11", lowcnt); end
    tests++; if (di !== 8'h5A || grant !== 7'b0100000) begin fails++; $display("FAIL rdy_data got %h/%b exp 5a/0100000", di, grant); end
    rd_n = 1'b1;
    edge1();
  endtask

  task automatic test_abort();
    wait_cfg[3*4 +: 4] = 4'd5;
    rd_n = 1'b0; req = 7'b0001000;
    edge1();
    edge1();
    tests++; if (wait_n !== 1'b0 || grant !== 7'b0001000) begin fails++; $display("FAIL abort_pre got %b/%b exp 0/0001000", wait_n, grant); end
    rd_n = 1'b1;
    edge1();
    tests++; if (grant !== 7'b0 || wait_n !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL abort_idle got g%b w%b b%b exp 0 1 0", grant, wait_n, busy); end
    tests++; if (di !== 8'h5A) begin fails++; $display("FAIL abort_di got %h exp 5a", di); end
    req = '0;
  endtask

  task automatic test_reset_hold();
    wait_cfg[1*4 +: 4] = 4'd0;
    dev_data[1*8 +: 8] = 8'h77;
    rd_n = 1'b0; req = 7'b0000010;
    edge1();
    edge1();
    tests++; if (di !== 8'h77 || busy !== 1'b1) begin fails++; $display("FAIL rh_hold got %h/%b exp 77/1", di, busy); end
    rst_n = 1'b0;
    #0.5;
    tests++; if (grant !== 7'b0 || wait_n !== 1'b1 || di !== 8'h00 || busy !== 1'b0) begin
      fails++; $display("FAIL rh_async got g%b w%b di%h b%b exp 0 1 00 0", grant, wait_n, di, busy); end
    rd_n = 1'b1; req = '0;
    @(negedge clk); rst_n = 1'b1;
    edge1();
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int lowcnt = 0;
    wait_cfg[4*4 +: 4] = 4'd0;
    dev_ready[4] = 1'b0;
    rd_n = 1'b0; req = 7'b0010000;
    for (int e = 0; e < 200; e++) begin
      edge1();
      if (wait_n === 1'b0) lowcnt++;
      else break;
    end
    tests++; if (lowcnt != 64) begin fails++; $display("FAIL tmo_cycles got %0d exp 64", lowcnt); end
    tests++; if (di !== 8'hFF || tmo !== 1'b1) begin fails++; $display("FAIL tmo_abort got %h/%b exp ff/1", di, tmo); end
    rd_n = 1'b1; req = '0; dev_ready[4] = 1'b1;
    edge1();
    rd_n = 1'b0; req = 7'b0000001;
    edge1();
    tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL tmo_clear got %b exp 0", tmo); end
    rd_n = 1'b1; req = '0;
    for (int i = 0; i < 5; i++) edge1();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_wait_states();
    test_priority();
    test_unclaimed();
    test_ready();
    test_abort();
    test_reset_hold();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
